// File: rtl/kyber_hpm_pkg.sv
// kyber_hpm_pkg: shared states, mode/error encodings and default sizes for the
// Kyber polynomial-multiplier sequencer.
package kyber_hpm_pkg;

    localparam int PE_NUMBER_DEF = 16;
    localparam int WORDS_DEF     = 16;

    localparam logic [1:0] MODE_MUL  = 2'd0;
    localparam logic [1:0] MODE_FNTT = 2'd1;
    localparam logic [1:0] MODE_INTT = 2'd2;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_GAP     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_MODE    = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_FNTT,
        S_PWM,
        S_INTT,
        S_READ_WAIT,
        S_READ,
        S_ERR
    } state_t;

endpackage

// File: rtl/kyber_hpm_phase_timer.sv
// kyber_hpm_phase_timer: down-counter reloaded at the start of every compute
// phase; expired marks the last cycle a phase may wait for core_done.
module kyber_hpm_phase_timer #(
    parameter int TW      = 12,
    parameter int TIMEOUT = 4095
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic expired
);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (start)
            cnt <= TW'(TIMEOUT - 1);
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    // The start cycle plus TIMEOUT-1 waiting cycles make up the whole budget.
    assign expired = cnt == TW'(1);

endmodule

// File: rtl/kyber_hpm_sequencer.sv
// kyber_hpm_sequencer: runs one command (multiply, forward NTT or inverse NTT)
// through the 16-PE core: load operands, start phases, await done, stream result.
module kyber_hpm_sequencer
    import kyber_hpm_pkg::*;
#(
    parameter int PE_NUMBER = PE_NUMBER_DEF,
    parameter int WORDS     = WORDS_DEF,
    parameter int READ_LAT  = 3,
    parameter int TIMEOUT   = 4095,
    parameter int TW        = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [12*PE_NUMBER-1:0] in_data,
    output logic                    out_valid,
    output logic [12*PE_NUMBER-1:0] out_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [1:0]              err_code,
    output logic                    core_load_a_f,
    output logic                    core_load_b_f,
    output logic                    core_read_a,
    output logic                    core_start_fntt,
    output logic                    core_start_pwm2,
    output logic                    core_start_intt,
    output logic [12*PE_NUMBER-1:0] core_din,
    input  logic [12*PE_NUMBER-1:0] core_dout,
    input  logic                    core_done
);

    localparam int CW = $clog2(WORDS);

    state_t        state, next;
    logic [1:0]    mode, code_next;
    logic [CW-1:0] cnt;
    logic          entry, ld, compute, last_phase, phase_done, hs, burst_end, expired;

    kyber_hpm_phase_timer #(.TW(TW), .TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (compute && entry),
        .expired (expired)
    );

    // entry marks the first cycle in a state; compute phases ignore core_done then.
    always_comb begin
        compute         = state inside {S_FNTT, S_PWM, S_INTT};
        last_phase      = state == S_INTT || (state == S_FNTT && mode == MODE_FNTT);
        phase_done      = compute && !entry && core_done;
        hs              = (state == S_LOAD_A || state == S_LOAD_B) && ld && in_valid;
        burst_end       = hs && cnt == CW'(WORDS - 1);
        core_load_a_f   = state == S_LOAD_A && !ld && in_valid;
        core_load_b_f   = state == S_LOAD_B && !ld && in_valid;
        core_start_fntt = state == S_FNTT && entry;
        core_start_pwm2 = state == S_PWM && entry;
        core_start_intt = state == S_INTT && entry;
        core_read_a     = phase_done && last_phase;
        core_din        = hs ? in_data : '0;
        in_ready        = ld;
        busy            = state != S_IDLE;
    end

    always_comb begin
        next      = state;
        code_next = ERR_NONE;
        case (state)
            S_IDLE: begin
                code_next = ERR_MODE;
                if (cmd_valid && cmd_ready)
                    next = cmd_mode == 2'd3 ? S_ERR : S_LOAD_A;
            end
            S_LOAD_A, S_LOAD_B: begin
                if (ld && !in_valid) begin
                    next      = S_ERR;
                    code_next = ERR_GAP;
                end else if (burst_end)
                    next = state == S_LOAD_B   ? S_FNTT :
                           mode == MODE_INTT   ? S_INTT :
                           mode == MODE_FNTT   ? S_FNTT : S_LOAD_B;
            end
            S_FNTT, S_PWM, S_INTT: begin
                if (phase_done)
                    next = last_phase ? S_READ_WAIT : state == S_FNTT ? S_PWM : S_INTT;
                else if (!entry && expired) begin
                    next      = S_ERR;
                    code_next = ERR_TIMEOUT;
                end
            end
            S_READ_WAIT: next = cnt == CW'(READ_LAT - 2) ? S_READ : S_READ_WAIT;
            S_READ:      next = cnt == CW'(WORDS - 1) ? S_IDLE : S_READ;
            default:     next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            mode      <= MODE_MUL;
            cnt       <= '0;
            entry     <= 1'b0;
            ld        <= 1'b0;
            cmd_ready <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            state     <= next;
            entry     <= next != state;
            cmd_ready <= next == S_IDLE;
            ld        <= (ld || core_load_a_f || core_load_b_f) && !burst_end && next != S_ERR;
            cnt       <= next != state ? '0 :
                         (hs || state == S_READ_WAIT || state == S_READ) ? cnt + 1'b1 : cnt;
            if (state == S_IDLE && cmd_valid && cmd_ready) begin
                mode     <= cmd_mode;
                err      <= 1'b0;
                err_code <= ERR_NONE;
            end
            if (next == S_ERR) begin
                err      <= 1'b1;
                err_code <= code_next;
            end
            out_valid <= state == S_READ;
            out_data  <= state == S_READ ? core_dout : '0;
            done      <= out_valid && state != S_READ;
        end
    end

endmodule

// File: tb/tb_kyber_hpm_sequencer.sv
// tb_kyber_hpm_sequencer: directed bench with a cycle-level core model that
// echoes the loaded A polynomial back on read-out.
module tb_kyber_hpm_sequencer;

    localparam int PE = 16;
    localparam int DW = 12 * PE;

    logic          clk = 1'b0, reset = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready;
    logic [1:0]    cmd_mode = 2'd0;
    logic          in_valid = 1'b0, in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid, busy, done, err;
    logic [DW-1:0] out_data, core_din;
    logic [DW-1:0] core_dout = '0;
    logic [1:0]    err_code;
    logic          core_load_a_f, core_load_b_f, core_read_a;
    logic          core_start_fntt, core_start_pwm2, core_start_intt;
    logic          core_done = 1'b0;

    kyber_hpm_sequencer #(.TIMEOUT(100)) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_mode        (cmd_mode),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .err_code        (err_code),
        .core_load_a_f   (core_load_a_f),
        .core_load_b_f   (core_load_b_f),
        .core_read_a     (core_read_a),
        .core_start_fntt (core_start_fntt),
        .core_start_pwm2 (core_start_pwm2),
        .core_start_intt (core_start_intt),
        .core_din        (core_din),
        .core_dout       (core_dout),
        .core_done       (core_done)
    );

    always #5 clk = ~clk;

    int            checks = 0, failures = 0;
    int            cyc = 0, done_at = -1, rd_at = -1000, f_cyc = 0;
    int            cap_sel = 0, cap_n = 0, cur_base = 0;
    int            nbeats = 0, bad_out = 0, ndone = 0, last_out_cyc = 0, done_cyc = 0;
    logic          hang = 1'b0, spur = 1'b0, saw_pwm = 1'b0;
    logic [31:0]   seq = '0;
    logic [DW-1:0] a_mem [16];
    logic [DW-1:0] b_mem [16];

    function automatic logic [DW-1:0] a_word(input int base, input int k);
        logic [DW-1:0] w;
        for (int j = 0; j < PE; j++) w[12*j +: 12] = 12'(base + 16*k + j);
        return w;
    endfunction

    // Core model inputs change 1 time unit after each rising edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        core_done = (cyc == done_at) || spur;
        core_dout = (cyc >= rd_at + 3 && cyc < rd_at + 19) ? a_mem[cyc - rd_at - 3] : {DW{1'b1}};
    end

    always @(negedge clk) begin
        if (cap_sel != 0 && cap_n < 16) begin
            if (cap_sel == 1) a_mem[cap_n] = core_din;
            else b_mem[cap_n] = core_din;
            cap_n++;
        end
        if (core_load_a_f) begin seq = {seq[27:0], 4'd1}; cap_sel = 1; cap_n = 0; end
        if (core_load_b_f) begin seq = {seq[27:0], 4'd2}; cap_sel = 2; cap_n = 0; end
        if (core_start_fntt) begin seq = {seq[27:0], 4'd3}; f_cyc = cyc; done_at = hang ? -1 : cyc + 40; end
        if (core_start_pwm2) begin seq = {seq[27:0], 4'd4}; saw_pwm = 1'b1; done_at = cyc + 40; end
        if (core_start_intt) begin seq = {seq[27:0], 4'd5}; done_at = cyc + 40; end
        if (core_read_a) begin seq = {seq[27:0], 4'd6}; rd_at = cyc; end
        if (out_valid) begin
            if (out_data !== a_word(cur_base, nbeats)) bad_out++;
            nbeats++;
            last_out_cyc = cyc;
        end
        if (done) begin ndone++; done_cyc = cyc; end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear(input int base);
        seq = '0; nbeats = 0; bad_out = 0; ndone = 0; done_at = -1; rd_at = -1000;
        cap_sel = 0; cap_n = 0; cur_base = base; saw_pwm = 1'b0;
    endtask

    task automatic issue(input logic [1:0] m);
        cmd_valid = 1'b1;
        cmd_mode  = m;
        tick();
        cmd_valid = 1'b0;
    endtask

    // One load pulse cycle with junk data, then beats 0..gap-1 of the burst.
    task automatic send(input int base, input int gap, input logic ones);
        in_valid = 1'b1;
        in_data  = {DW{1'b1}};
        tick();
        for (int k = 0; k < 16; k++) begin
            if (k == gap) begin
                in_valid = 1'b0;
                return;
            end
            in_data = ones ? {PE{12'd1}} : a_word(base, k);
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    function automatic logic [7:0] outs_vec();
        return {cmd_ready, busy, in_ready, out_valid, done, err, |err_code, |out_data};
    endfunction

    function automatic logic [6:0] pulses();
        return {core_load_a_f, core_load_b_f, core_read_a, core_start_fntt,
                core_start_pwm2, core_start_intt, |core_din};
    endfunction

    initial begin
        int bad_b;
        repeat (3) tick();
        check("reset_outputs", 32'(outs_vec()), 32'h0);
        check("reset_pulses", 32'(pulses()), 32'h0);
        reset = 1'b0;
        tick();
        check("ready_after_reset", 32'(cmd_ready), 32'h1);
        check("idle_not_busy", 32'(busy), 32'h0);

        clear(1);
        issue(2'd0);
        check("busy_after_accept", 32'(busy), 32'h1);
        check("ready_low_busy", 32'(cmd_ready), 32'h0);
        send(1, 16, 1'b0);
        send(0, 16, 1'b1);
        repeat (220) tick();
        bad_b = 0;
        for (int k = 0; k < 16; k++) if (b_mem[k] !== {PE{12'd1}}) bad_b++;
        check("mul_pulse_order", seq, 32'h0012_3456);
        check("mul_b_loaded", 32'(bad_b), 32'h0);
        check("mul_beats", 32'(nbeats), 32'd16);
        check("mul_data", 32'(bad_out), 32'h0);
        check("mul_done_count", 32'(ndone), 32'h1);
        check("mul_done_after_last", 32'(done_cyc - last_out_cyc), 32'h1);
        check("mul_err", 32'(err), 32'h0);
        check("mul_idle", 32'(busy), 32'h0);

        clear(1);
        issue(2'd0);
        send(1, 7, 1'b0);
        tick();
        check("gap_err", 32'(err), 32'h1);
        check("gap_code", 32'(err_code), 32'h1);
        check("gap_in_ready", 32'(in_ready), 32'h0);
        tick();
        check("gap_idle", 32'({busy, cmd_ready, err}), 32'h3);
        repeat (50) tick();
        check("gap_no_done", 32'(ndone), 32'h0);
        check("gap_pulses", seq, 32'h1);

        clear(300);
        issue(2'd1);
        check("err_cleared", 32'({err, err_code}), 32'h0);
        send(300, 16, 1'b0);
        repeat (150) tick();
        check("fntt_pulse_order", seq, 32'h136);
        check("fntt_beats", 32'(nbeats), 32'd16);
        check("fntt_data", 32'(bad_out), 32'h0);
        check("fntt_done_count", 32'(ndone), 32'h1);

        clear(600);
        issue(2'd2);
        send(600, 16, 1'b0);
        repeat (150) tick();
        check("intt_pulse_order", seq, 32'h156);
        check("intt_beats", 32'(nbeats), 32'd16);
        check("intt_data", 32'(bad_out), 32'h0);
        check("intt_done_count", 32'(ndone), 32'h1);

        clear(300);
        hang = 1'b1;
        issue(2'd1);
        send(300, 16, 1'b0);
        for (int i = 0; i < 300 && !err; i++) tick();
        check("timeout_code", 32'(err_code), 32'h2);
        check("timeout_latency", 32'(cyc - f_cyc), 32'd100);
        hang = 1'b0;
        repeat (2) tick();
        check("timeout_idle", 32'({busy, ndone != 0}), 32'h0);

        clear(0);
        issue(2'd3);
        check("mode3_err", 32'({err, err_code}), 32'h7);
        tick();
        check("mode3_idle", 32'(busy), 32'h0);
        spur = 1'b1;
        tick();
        tick();
        spur = 1'b0;
        tick();
        check("spurious_done_idle", 32'({busy, cmd_ready}), 32'h1);
        check("mode3_no_pulses", seq, 32'h0);
        check("mode3_sticky", 32'({err, err_code}), 32'h7);

        clear(1);
        issue(2'd0);
        send(1, 16, 1'b0);
        send(0, 16, 1'b1);
        for (int i = 0; i < 200 && !saw_pwm; i++) tick();
        check("reached_pwm", 32'(saw_pwm), 32'h1);
        repeat (5) tick();
        reset = 1'b1;
        done_at = -1;
        #1;
        check("abort_outputs", 32'(outs_vec()), 32'h0);
        check("abort_pulses", 32'(pulses()), 32'h0);
        tick();
        reset = 1'b0;
        repeat (30) tick();
        check("abort_no_done", 32'(ndone), 32'h0);

        clear(600);
        issue(2'd2);
        send(600, 16, 1'b0);
        repeat (150) tick();
        check("recover_pulse_order", seq, 32'h156);
        check("recover_data", 32'({nbeats[7:0], bad_out[7:0]}), 32'h1000);
        check("recover_done", 32'({ndone[7:0], 7'd0, err}), 32'h100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kyber_hpm_sequencer.md
Name: kyber_hpm_sequencer

Overview:
- Command-level controller that sequences the 16-PE Kyber polynomial-multiplier core through complete operations: full multiply, forward NTT only, or inverse NTT only.
- Accepts one command, streams operand coefficients into the core, issues the phase start pulses, waits for each core done, then streams the result out.
- Sits between the host/DMA stream and the core top wrapper.
- Core inputs load_a_i, load_b_i, read_b and start_ab are not driven by this block; the instantiating level ties them low.

Parameters:
- PE_NUMBER, 16, coefficients per beat; data width is 12*PE_NUMBER.
- WORDS, 16, beats per polynomial (256/PE_NUMBER).
- READ_LAT, 3, cycles from the core_read_a pulse to the first valid core_dout word, including the core wrapper registers.
- TIMEOUT, 4095, maximum cycles to wait for core_done in any compute phase.
- TW, 12, timeout counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_mode  in  2  0 = multiply (A,B); 1 = forward NTT of A; 2 = inverse NTT of A; 3 = illegal
- in_valid  in  1  operand beat valid
- in_ready  out  1  sequencer accepting an operand beat
- in_data  in  12*PE_NUMBER  operand beat, coefficient 0 in the LSBs
- out_valid  out  1  result beat valid; no backpressure
- out_data  out  12*PE_NUMBER  result beat
- busy  out  1  high whenever the state is not IDLE
- done  out  1  one-cycle pulse after the last result beat
- err  out  1  sticky error flag, cleared by the next accepted command
- err_code  out  2  1 = input gap, 2 = timeout, 3 = illegal mode
- core_load_a_f, core_load_b_f, core_read_a, core_start_fntt, core_start_pwm2, core_start_intt  out  1 each  one-cycle pulses to the core
- core_din  out  12*PE_NUMBER  data to the core
- core_dout  in  12*PE_NUMBER  data from the core
- core_done  in  1  core phase-complete pulse

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- Reset asserted mid-operation aborts immediately; no done pulse is issued.
- States: IDLE, LOAD_A, LOAD_B, FNTT, PWM, INTT, READ_WAIT, READ, ERR.
- Command accept: cmd_valid && cmd_ready.
  - Latches the mode and clears err/err_code.
  - Mode 3: go to ERR with code 3.
  - Any other mode: go to LOAD_A.
- LOAD_A/LOAD_B entry and pulse:
  - State waits, with in_ready = 0, until in_valid is first seen.
  - On that cycle: pulse core_load_a_f (or core_load_b_f) and raise in_ready.
- Burst transfer:
  - Each following cycle with in_valid && in_ready drives core_din = in_data and increments the beat counter.
  - The burst is exactly WORDS contiguous beats.
- Input gap: in_valid low after the load pulse and before the burst completes -> ERR with code 1; in_ready drops the same cycle.
- After the last beat of a burst:
  - LOAD_A goes to LOAD_B in mode 0 and to FNTT in mode 1.
  - In mode 2, LOAD_A goes directly to INTT.
  - LOAD_B goes to FNTT.
- Phase sequence:
  - Mode 0: FNTT -> PWM -> INTT.
  - Mode 1: FNTT only.
  - Mode 2: INTT only.
- Phase timing:
  - Each compute phase pulses its core start on its first cycle.
  - The timeout counter restarts on entry to each phase.
  - core_done advances to the next phase. It is ignored on the entry (pulse) cycle and in every non-compute state.
  - core_done not seen within TIMEOUT cycles -> ERR with code 2.
- After the final phase: pulse core_read_a; enter READ_WAIT for READ_LAT-1 cycles; then enter READ.
- READ:
  - For WORDS cycles: out_valid = 1 and out_data = core_dout, registered from core_dout.
  - done pulses on the cycle after the last beat; return to IDLE.
- ERR:
  - Holds for one cycle, asserting err and the code.
  - Returns to IDLE; err and err_code stay asserted.
  - No done pulse.
- A cmd_valid held during busy is not accepted; cmd_ready = 0 outside IDLE.
- Multiply latency: roughly 2*(WORDS+1) load cycles + core phase latencies + READ_LAT + WORDS.

Decomposition:
- Shared package kyber_hpm_pkg holds:
  - the state enumeration;
  - the mode constants MODE_MUL = 0, MODE_FNTT = 1, MODE_INTT = 2;
  - the error-code constants;
  - the default WORDS/PE_NUMBER values.
- One sub-module: kyber_hpm_phase_timer, a loadable down-counter with a start input and an expired output, reused across all phases.

Test Plan:
- Mode 0 with a cycle-accurate core model (phase done 40 cycles after start), gapless input of A = 1..256 and B = all 1 -> pulse order load_a_f, load_b_f, fntt, pwm2, intt, read_a; 16 out beats matching the model; single done pulse; err = 0.
- Mode 1 and mode 2 -> only the load_a_f pulse plus a single start pulse (start_fntt or start_intt respectively), then 16 out beats and done; core_load_b_f never pulses.
- in_valid dropped at beat 7 of the A burst -> err = 1, err_code = 1, return to IDLE; no done; next command clears err.
- core model never asserts done, TIMEOUT = 100 -> err_code = 2 exactly 100 cycles after the fntt pulse.
- cmd_mode = 3 -> err_code = 3, no core pulses; spurious core_done in IDLE -> no state change.
- reset asserted during PWM -> all outputs 0 next edge; a new command afterwards completes normally.
